fetch_pc_gen: RTL and testbench

//  Fetch-stage next-PC generator. Holds the fetch PC, drives the direction predictor (is_br, pc_idx) and consumes its br_pred.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/btb_table.sv | 33 +++
 rtl/fetch_pc_gen.sv | 119 +++++++++++
 tb/tb_fetch_pc_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator.
// N_ENTRY_BHR (direction-predictor table size) is supplied by the predictor build; 16 if absent.
`ifndef N_ENTRY_BHR
`define N_ENTRY_BHR 16
`endif

package fetch_pkg;

    localparam int unsigned N_BTB_DEFAULT = 16;
    localparam int unsigned PC_W_DEFAULT  = 64;
    localparam int unsigned BTB_IDX_W     = $clog2(N_BTB_DEFAULT);
    localparam int unsigned BTB_TAG_W     = PC_W_DEFAULT - 2 - BTB_IDX_W;
    localparam int unsigned PC_INC        = 4;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_W-1:0]    tag;
        logic [PC_W_DEFAULT-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: one combinational read port, one write port, synchronous clear.
// The entry type is a parameter so the tagged and untagged builds share this storage.
module btb_table
    import fetch_pkg::*;
#(
    parameter int unsigned Depth   = N_BTB_DEFAULT,
    parameter type         entry_t = btb_entry_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(Depth)-1:0] rd_idx_i,
    output entry_t                   rd_entry_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_idx_i,
    input  entry_t                   wr_entry_i
);

    entry_t entries_q [Depth];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                entries_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            entries_q[wr_idx_i] <= wr_entry_i;
        end
    end

    // Reads see the pre-write contents; a same-cycle write shows up next cycle.
    assign rd_entry_o = entries_q[rd_idx_i];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: PC register, BTB lookup/training and next-PC mux.
// Define BTB_TAG_EN to store and compare per-entry tags; otherwise aliasing PCs share entries.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned     N_BTB    = N_BTB_DEFAULT,
    parameter int unsigned     PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             fetch_stall_i,
    input  logic                             ex_redirect_valid_i,
    input  logic [PC_W-1:0]                  ex_redirect_pc_i,
    input  logic                             ex_br_valid_i,
    input  logic                             ex_br_taken_i,
    input  logic [PC_W-1:0]                  ex_br_pc_i,
    input  logic [PC_W-1:0]                  ex_br_target_i,
    input  logic                             dirp_br_pred_i,
    output logic                             dirp_is_br_o,
    output logic [$clog2(`N_ENTRY_BHR)-1:0]  dirp_pc_idx_o,
    output logic [PC_W-1:0]                  if_pc_o,
    output logic                             if_valid_o,
    output logic                             if_pred_taken_o,
    output logic [PC_W-1:0]                  if_pred_target_o
);

    localparam int unsigned IdxW    = $clog2(N_BTB);
    localparam int unsigned TagW    = PC_W - 2 - IdxW;
    localparam int unsigned BhrIdxW = $clog2(`N_ENTRY_BHR);

`ifdef BTB_TAG_EN
    typedef struct packed {
        logic            valid;
        logic [TagW-1:0] tag;
        logic [PC_W-1:0] target;
    } entry_t;
`else
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] target;
    } entry_t;
`endif

    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q;
    logic [IdxW-1:0] rd_idx, wr_idx;
    entry_t          rd_entry, wr_entry;
    logic            wr_en, hit, pred_taken;
    logic [PC_W-1:0] seq_pc, pred_target;
    logic            unused_bits;

    assign rd_idx = pc_q[2 +: IdxW];
    assign wr_idx = ex_br_pc_i[2 +: IdxW];
    assign wr_en  = ex_br_valid_i & ex_br_taken_i;

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
`ifdef BTB_TAG_EN
        wr_entry.tag    = ex_br_pc_i[PC_W-1 -: TagW];
`endif
        wr_entry.target = {ex_br_target_i[PC_W-1:2], 2'b00};
    end

    btb_table #(
        .Depth   (N_BTB),
        .entry_t (entry_t)
    ) u_btb (
        .clock      (clock),
        .reset      (reset),
        .rd_idx_i   (rd_idx),
        .rd_entry_o (rd_entry),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_entry_i (wr_entry)
    );

    // Entries may still be valid during the first reset cycle, so the hint is gated by reset.
`ifdef BTB_TAG_EN
    assign hit = ~reset & rd_entry.valid & (rd_entry.tag == pc_q[PC_W-1 -: TagW]);
`else
    assign hit = ~reset & rd_entry.valid;
`endif

    assign seq_pc      = pc_q + PC_W'(PC_INC);
    assign pred_taken  = hit & dirp_br_pred_i;
    assign pred_target = pred_taken ? rd_entry.target : seq_pc;

    // The first cycle out of reset holds RESET_PC so that it is fetched as a valid request.
    always_comb begin
        pc_d = pred_target;
        if (ex_redirect_valid_i) begin
            pc_d = {ex_redirect_pc_i[PC_W-1:2], 2'b00};
        end else if (fetch_stall_i || !valid_q) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

    assign dirp_is_br_o     = hit;
    assign dirp_pc_idx_o    = pc_q[2 +: BhrIdxW];
    assign if_pc_o          = pc_q;
    assign if_valid_o       = valid_q & ~ex_redirect_valid_i & ~reset;
    assign if_pred_taken_o  = pred_taken;
    assign if_pred_target_o = pred_target;

    assign unused_bits = ^{ex_br_pc_i, ex_br_target_i[1:0], ex_redirect_pc_i[1:0]};

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized bench for fetch_pc_gen against a behavioural model of PC sequencing and the BTB.
`ifndef N_ENTRY_BHR
`define N_ENTRY_BHR 16
`endif

module tb_fetch_pc_gen;

    localparam int unsigned NBtb    = 16;
    localparam logic [63:0] ResetPc = 64'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_stall, ex_redirect_valid, ex_br_valid, ex_br_taken, dirp_br_pred;
    logic [63:0] ex_redirect_pc, ex_br_pc, ex_br_target;
    logic        dirp_is_br, if_valid, if_pred_taken;
    logic [$clog2(`N_ENTRY_BHR)-1:0] dirp_pc_idx;
    logic [63:0] if_pc, if_pred_target;

    always #5 clock = ~clock;

    fetch_pc_gen #(
        .N_BTB    (NBtb),
        .PC_W     (64),
        .RESET_PC (ResetPc)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .fetch_stall_i       (fetch_stall),
        .ex_redirect_valid_i (ex_redirect_valid),
        .ex_redirect_pc_i    (ex_redirect_pc),
        .ex_br_valid_i       (ex_br_valid),
        .ex_br_taken_i       (ex_br_taken),
        .ex_br_pc_i          (ex_br_pc),
        .ex_br_target_i      (ex_br_target),
        .dirp_br_pred_i      (dirp_br_pred),
        .dirp_is_br_o        (dirp_is_br),
        .dirp_pc_idx_o       (dirp_pc_idx),
        .if_pc_o             (if_pc),
        .if_valid_o          (if_valid),
        .if_pred_taken_o     (if_pred_taken),
        .if_pred_target_o    (if_pred_target)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the fetch PC, whether it is live, and a table of (branch PC, target) pairs.
    logic [63:0] m_pc;
    bit          m_pc_known = 1'b0;
    bit          m_live;
    bit          m_bv   [NBtb];
    logic [63:0] m_bpc  [NBtb];
    logic [63:0] m_btgt [NBtb];

    function automatic int m_idx(input logic [63:0] pc);
        return int'((pc / 4) % NBtb);
    endfunction

    function automatic bit m_hit();
        int i;
        i = m_idx(m_pc);
        if (reset || !m_bv[i]) return 1'b0;
`ifdef BTB_TAG_EN
        return (m_bpc[i] / (4 * NBtb)) == (m_pc / (4 * NBtb));
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [63:0] m_target();
        if (m_hit() && dirp_br_pred) return m_btgt[m_idx(m_pc)];
        return m_pc + 64'd4;
    endfunction

    task automatic apply(input bit rst, input bit stall, input bit rv, input logic [63:0] rpc,
                         input bit bv, input bit bt, input logic [63:0] bpc,
                         input logic [63:0] btg, input bit pred);
        @(negedge clock);
        reset = rst; fetch_stall = stall; ex_redirect_valid = rv; ex_redirect_pc = rpc;
        ex_br_valid = bv; ex_br_taken = bt; ex_br_pc = bpc; ex_br_target = btg;
        dirp_br_pred = pred;
        #1;
        check_val("is_br", dirp_is_br, m_hit());
        check_val("pred_taken", if_pred_taken, m_hit() && pred);
        check_val("if_valid", if_valid, m_live && !rv && !rst);
        if (m_pc_known) begin
            check_val("if_pc", if_pc, m_pc);
            check_val("pc_idx", dirp_pc_idx, (m_pc / 4) % `N_ENTRY_BHR);
            check_val("pred_target", if_pred_target, m_target());
        end
    endtask

    task automatic tick();
        logic [63:0] nxt;
        @(posedge clock);
        if (reset) begin
            m_pc = ResetPc; m_pc_known = 1'b1; m_live = 1'b0;
            for (int i = 0; i < int'(NBtb); i++) m_bv[i] = 1'b0;
        end else begin
            if (ex_redirect_valid)          nxt = ex_redirect_pc & ~64'h3;
            else if (fetch_stall || !m_live) nxt = m_pc;
            else                            nxt = m_target();
            if (ex_br_valid && ex_br_taken) begin
                m_bv[m_idx(ex_br_pc)]   = 1'b1;
                m_bpc[m_idx(ex_br_pc)]  = ex_br_pc;
                m_btgt[m_idx(ex_br_pc)] = ex_br_target & ~64'h3;
            end
            m_pc = nxt; m_live = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input bit pred);
        apply(0, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, pred);
        tick();
    endtask

    task automatic redirect(input logic [63:0] pc);
        apply(0, 0, 1, pc, 0, 0, 64'h0, 64'h0, 0);
        tick();
    endtask

    function automatic logic [63:0] rnd_pc();
        logic [31:0] hi;
        hi = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        return {hi, 32'($urandom_range(0, 255))};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_live = 1'b0;
        for (int i = 0; i < int'(NBtb); i++) m_bv[i] = 1'b0;

        // Reset, then sequential fetch from RESET_PC.
        apply(1, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 0); tick();
        apply(1, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 0); tick();
        idle(0);
        check_val("first_pc", if_pc, 64'h0);
        apply(0, 0, 0, 64'h0, 1, 1, 64'h10, 64'h80, 0); tick();
        check_val("seq_pc4", if_pc, 64'h4);
        idle(0); check_val("seq_pc8", if_pc, 64'h8);
        idle(0); check_val("seq_pc12", if_pc, 64'hC);
        idle(0);

        // Taken prediction through the BTB, then not-taken fallthrough.
        apply(0, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 1);
        check_val("hit_0x10", dirp_is_br, 1'b1);
        check_val("tgt_0x80", if_pred_target, 64'h80);
        tick();
        check_val("pc_taken", if_pc, 64'h80);
        redirect(64'h10);
        idle(0);
        check_val("pc_fallthru", if_pc, 64'h14);

        // Redirect beats stall and a taken hit; squashed PC reported invalid.
        redirect(64'h10);
        apply(0, 1, 1, 64'h200, 0, 0, 64'h0, 64'h0, 1);
        check_val("squash_valid", if_valid, 1'b0);
        tick();
        check_val("redir_pc", if_pc, 64'h200);

        // Same-cycle write and lookup on one index.
        apply(0, 1, 0, 64'h0, 1, 1, 64'h200, 64'h303, 1);
        check_val("wr_rd_old", dirp_is_br, 1'b0);
        tick();
        apply(0, 1, 0, 64'h0, 0, 0, 64'h0, 64'h0, 1);
        check_val("wr_rd_new", dirp_is_br, 1'b1);
        check_val("wr_rd_tgt", if_pred_target, 64'h300);
        tick();

        // Alias of 0x10 at 0x10 + 4*N_BTB.
        redirect(64'h10 + 64'(4 * NBtb));
        apply(0, 0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 1);
`ifdef BTB_TAG_EN
        check_val("alias_hit", dirp_is_br, 1'b0);
`else
        check_val("alias_hit", dirp_is_br, 1'b1);
`endif
        tick();

        // Wrap of pc+4 at the top of the address space.
        redirect(64'hFFFF_FFFF_FFFF_FFFF);
        check_val("top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(1);
        check_val("wrap_pc", if_pc, 64'h0);

        for (int n = 0; n < 500; n++) begin
            apply($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, rnd_pc(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, rnd_pc(),
                  {32'h0, $urandom}, $urandom_range(0, 1) == 1);
            tick();
        end

        // Mid-run reset drops a same-cycle update and clears the table.
        apply(1, 0, 0, 64'h0, 1, 1, 64'h3C, 64'h400, 1); tick();
        check_val("rst_pc", if_pc, ResetPc);
        for (int n = 0; n < 18; n++) idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
